// File: rtl/data_mem_dump.sv
// data_mem_dump: reads back the whole data memory after a program run and
// streams every byte, tagged with its address, over a valid/ready port.
// Each byte costs one READ, one WAIT (memory latency) and at least one SEND
// cycle. Beats are not pipelined, so the read port stays idle while a beat
// waits for the sink.
//
// Optional feature macro: DUMP_CHECKSUM_EN
//   defined   -> one extra beat after the last data beat carries the sum of
//                all dumped bytes (mod 2**DATA_W) at address 0 with out_last=1
//   undefined -> out_last is raised on the data beat at DEPTH-1
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; everything quiet
// READ  | one-cycle read strobe for address idx
// WAIT  | memory latency; read data captured into out_data at the edge
// SEND  | data beat for idx held on the stream until accepted
// CSUM  | checksum beat held on the stream until accepted (feature only)
// DONE  | one-cycle done pulse, then back to IDLE
//
// abort in any state but IDLE returns to IDLE at the next edge without a
// done pulse; a beat that was offered but not yet accepted is dropped.

module data_mem_dump #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  // Last address dumped; idx never counts past it, so idx cannot wrap.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd5
  } state_t;
`endif

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] rd_addr_hold;
  logic [DATA_W-1:0] data_q;
  logic              start_go;
  logic              xfer;
  logic              at_last;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  // abort beats start when both arrive together in IDLE
  assign start_go = (state == S_IDLE) && start && !abort;
  assign xfer     = out_valid && out_ready;
  assign at_last  = (idx == LAST_IDX);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort takes priority in every busy state
  always_comb begin
    state_nxt = state;
    if ((state != S_IDLE) && abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_go) begin
            state_nxt = S_READ;
          end
        end
        S_READ: state_nxt = S_WAIT;
        S_WAIT: state_nxt = S_SEND;
        S_SEND: begin
          if (xfer) begin
            if (!at_last) begin
              state_nxt = S_READ;
            end else begin
`ifdef DUMP_CHECKSUM_EN
              state_nxt = S_CSUM;
`else
              state_nxt = S_DONE;
`endif
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) begin
            state_nxt = S_DONE;
          end
        end
`endif
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Address walker, held read address and captured read data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx          <= '0;
      rd_addr_hold <= '0;
      data_q       <= '0;
    end else begin
      if (start_go) begin
        idx <= '0;
      end else if ((state == S_SEND) && xfer && !abort && !at_last) begin
        idx <= idx + ADDR_W'(1);
      end
      if (state == S_READ) begin
        rd_addr_hold <= idx;
      end
      if (state == S_WAIT) begin
        data_q <= mem_rd_data;
      end
    end
  end

`ifdef DUMP_CHECKSUM_EN
  // Running sum of dumped bytes; restarts with every accepted start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      csum <= '0;
    end else if (start_go) begin
      csum <= '0;
    end else if (state == S_WAIT) begin
      csum <= csum + mem_rd_data;
    end
  end
`endif

  // Outputs decoded from the current state
  always_comb begin
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    mem_rd_en   = (state == S_READ);
    mem_rd_addr = rd_addr_hold;
    out_valid   = 1'b0;
    out_data    = data_q;
    out_addr    = '0;
    out_last    = 1'b0;
    case (state)
      S_READ: begin
        mem_rd_addr = idx;
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_addr  = idx;
`ifdef DUMP_CHECKSUM_EN
        out_last  = 1'b0;
`else
        out_last  = at_last;
`endif
      end
`ifdef DUMP_CHECKSUM_EN
      S_CSUM: begin
        out_valid = 1'b1;
        out_data  = csum;
        out_addr  = '0;
        out_last  = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_data_mem_dump.sv
// Bench for data_mem_dump: table of dump scenarios plus hand-written abort,
// reset and start-filtering sequences. Expected beats go into a queue when a
// dump is started and are popped as the sink accepts beats.
// Honours DUMP_CHECKSUM_EN the same way as the design.

module tb_data_mem_dump;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
`ifdef DUMP_CHECKSUM_EN
  localparam int EXP_BEATS = DEPTH + 1;
  localparam bit CSUM_ON   = 1'b1;
`else
  localparam int EXP_BEATS = DEPTH;
  localparam bit CSUM_ON   = 1'b0;
`endif

  logic              clock;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  data_mem_dump #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model with one cycle of read latency
  logic [DATA_W-1:0] mem [DEPTH];
  initial begin
    mem_rd_data = '0;
    forever begin
      @(posedge clock);
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end
  end

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    logic              l;
  } beat_t;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] fill;
    int         stall_pct;
    int         stall_addr;
    bit         extra_start;
    logic [7:0] exp_sum;
  } vec_t;

  vec_t  tbl [5];
  beat_t exp_q [$];

  int vectors     = 0;
  int miscompares = 0;
  int beat_cnt    = 0;
  int done_cnt    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sink-side monitor: scoreboard pops, stall stability, done counting
  initial begin
    logic              held;
    logic [DATA_W-1:0] h_d;
    logic [ADDR_W-1:0] h_a;
    logic              h_l;
    beat_t             e;
    held = 1'b0;
    h_d  = '0;
    h_a  = '0;
    h_l  = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", 32'(out_data), 32'(h_d));
          check("stall_addr", 32'(out_addr), 32'(h_a));
          check("stall_last", 32'(out_last), 32'(h_l));
          check("stall_rd_en", 32'(mem_rd_en), 32'd0);
        end
        if (out_valid && out_ready) begin
          beat_cnt++;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: got addr %0h data %0h, no beat expected", out_addr, out_data);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 32'(out_data), 32'(e.d));
            check("beat_addr", 32'(out_addr), 32'(e.a));
            check("beat_last", 32'(out_last), 32'(e.l));
          end
        end
        if (done) done_cnt++;
        held = out_valid && !out_ready && !abort;
        h_d  = out_data;
        h_a  = out_addr;
        h_l  = out_last;
      end
    end
  end

  task automatic load_mem(input int r);
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = (i == 0) ? tbl[r].b0 : (i == 1) ? tbl[r].b1 : tbl[r].fill;
    end
  endtask

  task automatic push_expected(input int r);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(beat_t'{d: mem[i], a: ADDR_W'(i), l: (i == DEPTH - 1) && !CSUM_ON});
    end
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(beat_t'{d: tbl[r].exp_sum, a: '0, l: 1'b1});
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(mem_rd_addr), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'd0);
    check({tag, "_addr"}, 32'(out_addr), 32'd0);
    check({tag, "_last"}, 32'(out_last), 32'd0);
  endtask

  // Full dump of table row r, with the row's sink back-pressure pattern
  task automatic run_dump(input int r);
    int stall_left;
    bit seen;
    load_mem(r);
    push_expected(r);
    beat_cnt   = 0;
    done_cnt   = 0;
    stall_left = 5;
    seen       = 1'b0;
    start      = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
      if (tbl[r].stall_addr >= 0 && out_valid && out_addr == ADDR_W'(tbl[r].stall_addr)
          && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(99) >= tbl[r].stall_pct);
      end
      start = tbl[r].extra_start && (cyc == 20 || cyc == 21);
      @(posedge clock);
      #1;
      if (done) begin
        seen = 1'b1;
        check("done_busy", 32'(busy), 32'd1);
        check("done_valid", 32'(out_valid), 32'd0);
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL dump_timeout: row %0d got no done, expected done", r);
    end
    @(posedge clock);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("done_width", 32'(done), 32'd0);
    @(negedge clock);
    #1;
    check("queue_left", 32'(exp_q.size()), 32'd0);
    check("beat_count", 32'(beat_cnt), 32'(EXP_BEATS));
    check("done_count", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    bit seen;
    tbl[0] = '{8'hBB, 8'h77, 8'h00, 0,  -1, 1'b0, 8'h32};
    tbl[1] = '{8'h01, 8'h02, 8'h10, 30, -1, 1'b0, 8'hE3};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 50, -1, 1'b1, 8'hF0};
    tbl[3] = '{8'hBB, 8'h77, 8'h00, 0,   3, 1'b0, 8'h32};
    tbl[4] = '{8'h5A, 8'hA5, 8'h01, 20, -1, 1'b0, 8'h0D};

    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    for (int r = 0; r < 5; r++) run_dump(r);

    // abort while the beat for address 7 is on offer
    load_mem(0);
    push_expected(0);
    done_cnt = 0;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    seen  = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      if (out_valid && out_addr == 4'd7) seen = 1'b1;
      else begin
        @(posedge clock);
        #1;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL abort_wait: got no beat at addr 7, expected one");
    end
    out_ready = 1'b0;
    abort     = 1'b1;
    @(posedge clock);
    #1;
    abort     = 1'b0;
    out_ready = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_beats_left", 32'(exp_q.size()), 32'(EXP_BEATS - 7));
    repeat (5) @(posedge clock);
    #1;
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_stays_idle", 32'(busy), 32'd0);
    exp_q.delete();
    run_dump(0);

    // reset pulled while the read of address 9 is in its WAIT cycle
    load_mem(0);
    push_expected(0);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    seen  = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      if (mem_rd_en && mem_rd_addr == 4'd9) seen = 1'b1;
      else begin
        @(posedge clock);
        #1;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL reset_wait: got no read of addr 9, expected one");
    end
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    @(posedge clock);
    #1;
    run_dump(0);

    // start together with abort in IDLE is ignored
    start = 1'b1;
    abort = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    @(posedge clock);
    #1;
    check("start_abort_rd_en", 32'(mem_rd_en), 32'd0);
    check("start_abort_busy2", 32'(busy), 32'd0);
    check("start_abort_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
